uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Round-robin scheduler and bit-serial driver that shares the single UART TX line between NUM_REQ byte requesters.
- Each requester offers a byte with a valid/ready handshake.
- The block grants one requester at a time and frames its byte as 8N1, LSB first.
- Holds the line idle-high whenever it is not sending.
- Sits between message sources (debug/status generators, camera telemetry) and the board TX pin.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
CLK_DIV, 434, UART_CLK cycles per bit (434 = 115200 baud at 50 MHz); must be >= 2
GW, 1, GRANT_ID width; must equal max(1, ceil(log2(NUM_REQ)))

Ports:
UART_CLK  in  1  system clock, rising edge
UART_RST_N  in  1  asynchronous active-low reset
UART_EN  in  1  gates acceptance of new bytes
REQ_VALID  in  NUM_REQ  per-requester byte-available
REQ_DATA  in  8*NUM_REQ  requester i byte on [8i+7:8i]
REQ_READY  out  NUM_REQ  one-hot accept strobe
UART_TX  out  1  serial line, idle high
BUSY  out  1  frame in progress
GRANT_ID  out  GW  index of requester owning the current/last frame

Behaviour:
- Reset (async, UART_RST_N=0): UART_TX=1, BUSY=0, REQ_READY=0, GRANT_ID=0, state=IDLE, bit/baud counters=0, last-grant pointer=NUM_REQ-1, so requester 0 has first priority. Reset asserted mid-frame aborts the frame immediately; the line goes high without waiting for a clock edge.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - UART_TX=1, BUSY=0.
  - If UART_EN=1 and any REQ_VALID=1, the winner is the first valid index searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - REQ_READY[winner]=1 combinationally in that cycle; all other REQ_READY bits are 0.
  - On that edge: byte latched into a shift register, GRANT_ID and last_grant set to winner, state goes to START.
  - REQ_READY is never asserted outside IDLE or while UART_EN=0.
- START: UART_TX=0 for CLK_DIV cycles; BUSY=1.
- DATA: 8 bits, LSB first, each held CLK_DIV cycles; shift right on each bit boundary; 3-bit bit counter.
- STOP: UART_TX=1 for CLK_DIV cycles, then IDLE.
- Baud counter:
  - Counts 0..CLK_DIV-1 and resets on every state entry.
  - Bit boundary occurs when the count reaches CLK_DIV-1.
  - Width is clog2(CLK_DIV); no wrap artefacts.
- Latency: the handshake edge is cycle 0. UART_TX goes low in cycle 1 (registered output) and the frame occupies cycles 1..10*CLK_DIV. IDLE holds for at least 1 cycle, so back-to-back frame pitch is 10*CLK_DIV+1 cycles.
- UART_EN=0 mid-frame: the current frame completes unmodified; no new grant until UART_EN=1.
- REQ_VALID:
  - Requesters hold REQ_DATA stable while REQ_VALID=1 until REQ_READY.
  - Dropping valid before grant is legal; no byte is sent.
  - Valid changes during a frame do not affect that frame.
- Simultaneous valids: exactly one grant per IDLE cycle. The pointer guarantees each continuously valid requester is served within NUM_REQ frames.
- NUM_REQ=1: the arbiter degenerates to a single grant and GRANT_ID stays 0.
- UART_TX, BUSY and GRANT_ID are registered outputs; REQ_READY is the only combinational output.

Test Plan:
1. CLK_DIV=4, NUM_REQ=2, UART_EN=1, req0 valid 0x55 -> REQ_READY[0] high exactly 1 cycle. UART_TX: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then 1 for 4 cycles. BUSY=1 for 40 cycles, GRANT_ID=0.
2. Both requesters continuously valid (req0=0xA0, req1=0xB1) -> served in order 0,1,0,1. Decoded bytes A0,B1,A0,B1; start-bit falling edges exactly 41 cycles apart.
3. UART_EN=0 with req1 valid for 100 cycles -> REQ_READY=0, UART_TX=1. Raise UART_EN -> grant to req1 next cycle.
4. Drop UART_EN at cycle 15 of a frame sending 0x3C -> full 0x3C frame decoded. REQ_READY stays 0 afterwards despite valid.
5. Assert UART_RST_N=0 mid-DATA -> UART_TX=1 and BUSY=0 before the next clock edge. After release with both valid -> req0 granted first.
6. req0 raises valid at the same edge the req1 frame ends (last_grant=1) -> req0 granted in the following IDLE cycle; no cycle has more than one REQ_READY bit high.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter in front of an 8N1 bit-serial driver that shares one UART TX line
// between NUM_REQ byte requesters with valid/ready handshakes.
module uart_tx_sched #(
  parameter int NUM_REQ = 2,
  parameter int CLK_DIV = 434,
  parameter int GW      = 1
) (
  input  logic                 UART_CLK,
  input  logic                 UART_RST_N,
  input  logic                 UART_EN,
  input  logic [NUM_REQ-1:0]   REQ_VALID,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]   REQ_READY,
  output logic                 UART_TX,
  output logic                 BUSY,
  output logic [GW-1:0]        GRANT_ID
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] IDX_LAST  = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last;

  logic [7:0]    w_bytes [NUM_REQ];
  logic [GW-1:0] w_winner;
  logic [GW-1:0] w_idx;
  logic          w_any;
  logic          w_accept;
  logic          w_bit_end;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_bytes[gi]   = REQ_DATA[8*gi +: 8];
      assign REQ_READY[gi] = w_accept && (w_winner == GW'(gi));
    end
  endgenerate

  // Walk upward from the slot after the last grant, wrapping; the first valid slot wins.
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    w_idx    = r_last;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (w_idx == IDX_LAST) ? '0 : w_idx + 1'b1;
      if (!w_any && REQ_VALID[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Reset is folded in so the strobe is low while the block is held in reset.
  assign w_accept  = UART_RST_N && UART_EN && w_any && (r_state == S_IDLE);
  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge UART_CLK or negedge UART_RST_N) begin
    if (!UART_RST_N) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_grant <= '0;
      r_last  <= IDX_LAST;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_accept) begin
            r_state <= S_START;
            r_shift <= w_bytes[w_winner];
            r_grant <= w_winner;
            r_last  <= w_winner;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign UART_TX  = r_tx;
  assign BUSY     = r_busy;
  assign GRANT_ID = r_grant;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: per-cycle line/handshake reference model plus vector table,
// directed corner sequences and randomized requester traffic.
module tb_uart_tx_sched;

  localparam int NR    = 2;
  localparam int CD    = 4;
  localparam int GWID  = 1;
  localparam int FRAME = 10 * CD;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            en    = 1'b0;
  logic [NR-1:0]   valid = '0;
  logic [7:0]      d0    = '0;
  logic [7:0]      d1    = '0;
  logic [NR-1:0]   ready;
  logic            tx;
  logic            busy;
  logic [GWID-1:0] gid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_tx_sched #(.NUM_REQ(NR), .CLK_DIV(CD), .GW(GWID)) dut (
    .UART_CLK  (clk),
    .UART_RST_N(rst_n),
    .UART_EN   (en),
    .REQ_VALID (valid),
    .REQ_DATA  ({d1, d0}),
    .REQ_READY (ready),
    .UART_TX   (tx),
    .BUSY      (busy),
    .GRANT_ID  (gid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the expected line level for every future cycle sits in a queue;
  // a grant appends a whole frame, and the block is idle exactly when the queue is empty.
  bit            m_q[$];
  int            m_last = NR - 1;
  int            m_grant = 0;
  logic [NR-1:0] m_rdy = '0;

  always @(negedge clk) begin : model
    logic          etx;
    logic          ebusy;
    logic [NR-1:0] erdy;
    logic [7:0]    bval;
    int            w;
    if (!rst_n) begin
      m_q.delete();
      m_last  = NR - 1;
      m_grant = 0;
      m_rdy   = '0;
      chk("rst_tx", int'(tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(ready), 0);
      chk("rst_grant_id", int'(gid), 0);
    end else begin
      erdy = '0;
      w    = -1;
      if (m_q.size() == 0) begin
        etx   = 1'b1;
        ebusy = 1'b0;
        if (en && valid != '0) begin
          for (int k = 1; k <= NR; k++)
            if (w < 0 && valid[(m_last + k) % NR]) w = (m_last + k) % NR;
          erdy[w] = 1'b1;
          bval = (w == 0) ? d0 : d1;
          for (int r = 0; r < CD; r++) m_q.push_back(1'b0);
          for (int b = 0; b < 8; b++)
            for (int r = 0; r < CD; r++) m_q.push_back(bval[b]);
          for (int r = 0; r < CD; r++) m_q.push_back(1'b1);
          $display("grant req=%0d byte=%02h cycle=%0d", w, bval, cyc);
        end
      end else begin
        etx   = m_q.pop_front();
        ebusy = 1'b1;
      end
      chk("tx", int'(tx), int'(etx));
      chk("busy", int'(busy), int'(ebusy));
      chk("ready", int'(ready), int'(erdy));
      chk("grant_id", int'(gid), m_grant);
      m_rdy = erdy;
      if (w >= 0) begin
        m_last  = w;
        m_grant = w;
      end
    end
  end

  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  task automatic samp_pt();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int limit, output logic [NR-1:0] r, output int c);
    r = '0;
    c = 0;
    for (int n = 0; n < limit; n++) begin
      samp_pt();
      if (ready != '0) begin
        r = ready;
        c = cyc;
        break;
      end
    end
    if (r == '0) chk("ready_timeout", int'(ready != '0), 1);
  endtask

  // Called right after a handshake; samples the line mid-bit for cycles 1..FRAME.
  task automatic decode(output logic [7:0] b);
    int nb;
    nb = 0;
    b  = '0;
    for (int n = 1; n <= FRAME; n++) begin
      samp_pt();
      if (busy) nb++;
      if (n == 2) chk("start_bit", int'(tx), 0);
      for (int k = 0; k < 8; k++)
        if (n == CD * (k + 1) + 2) b[k] = tx;
      if (n == 9 * CD + 2) chk("stop_bit", int'(tx), 1);
    end
    chk("busy_len", nb, FRAME);
  endtask

  typedef struct {
    logic          en;
    logic [NR-1:0] valid;
    logic [7:0]    d0;
    logic [7:0]    d1;
    int            hold;
    logic [NR-1:0] exp_rdy;
    logic [7:0]    exp_byte;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] r;
    logic [7:0]    b;
    int            c;
    int            hs[4];

    tbl[0] = '{1'b1, 2'b01, 8'h55, 8'h00, 1,   2'b01, 8'h55};
    tbl[1] = '{1'b1, 2'b11, 8'hA0, 8'hB1, 1,   2'b10, 8'hB1};
    tbl[2] = '{1'b1, 2'b11, 8'hA0, 8'hB1, 1,   2'b01, 8'hA0};
    tbl[3] = '{1'b0, 2'b10, 8'h00, 8'hC3, 100, 2'b00, 8'h00};
    tbl[4] = '{1'b1, 2'b10, 8'h00, 8'hC3, 1,   2'b10, 8'hC3};
    tbl[5] = '{1'b1, 2'b10, 8'h00, 8'h81, 1,   2'b10, 8'h81};
    tbl[6] = '{1'b1, 2'b00, 8'h00, 8'h00, 3,   2'b00, 8'h00};
    tbl[7] = '{1'b1, 2'b11, 8'hFF, 8'h00, 1,   2'b01, 8'hFF};

    repeat (3) drive_pt();
    rst_n = 1'b1;
    drive_pt();

    for (int i = 0; i < 8; i++) begin
      drive_pt();
      en    = tbl[i].en;
      valid = tbl[i].valid;
      d0    = tbl[i].d0;
      d1    = tbl[i].d1;
      for (int h = 0; h < tbl[i].hold; h++) begin
        samp_pt();
        chk("tbl_ready", int'(ready), int'(tbl[i].exp_rdy));
      end
      if (tbl[i].exp_rdy != '0) begin
        drive_pt();
        valid = '0;
        decode(b);
        chk("tbl_byte", int'(b), int'(tbl[i].exp_byte));
      end
    end

    // Enable dropped mid-frame: frame completes, no further grant while disabled.
    drive_pt();
    d0    = 8'h3C;
    valid = 2'b01;
    wait_ready(5, r, c);
    chk("en_drop_grant", int'(r), 1);
    drive_pt();
    valid = 2'b10;
    d1    = 8'h66;
    fork
      decode(b);
      begin
        repeat (14) drive_pt();
        en = 1'b0;
      end
    join
    chk("en_drop_byte", int'(b), 8'h3C);
    for (int n = 0; n < 50; n++) begin
      samp_pt();
      chk("en_off_ready", int'(ready), 0);
      chk("en_off_tx", int'(tx), 1);
    end

    // req1 frame, then req0 raises valid on the edge that frame ends.
    drive_pt();
    en = 1'b1;
    wait_ready(3, r, c);
    chk("en_on_grant", int'(r), 2);
    decode(b);
    chk("req1_byte", int'(b), 8'h66);
    drive_pt();
    valid = 2'b11;
    d0    = 8'h11;
    samp_pt();
    chk("end_edge_grant", int'(ready), 1);

    // Reset in the middle of the data bits of that frame.
    drive_pt();
    valid = 2'b00;
    repeat (14) samp_pt();
    #2;
    c     = cyc;
    rst_n = 1'b0;
    d0    = 8'hA0;
    d1    = 8'hB1;
    valid = 2'b11;
    #1;
    chk("async_rst_tx", int'(tx), 1);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_ready", int'(ready), 0);
    chk("async_rst_no_edge", cyc, c);
    repeat (2) drive_pt();
    rst_n = 1'b1;

    // Both continuously valid after reset: 0,1,0,1 with fixed frame pitch.
    for (int f = 0; f < 4; f++) begin
      wait_ready(3 * FRAME, r, c);
      chk("rr_order", int'(r), (f % 2 == 0) ? 1 : 2);
      hs[f] = c;
      decode(b);
      chk("rr_byte", int'(b), (f % 2 == 0) ? 8'hA0 : 8'hB1);
      if (f > 0) chk("rr_pitch", hs[f] - hs[f-1], FRAME + 1);
    end
    drive_pt();
    valid = '0;

    // Randomized traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      drive_pt();
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NR; i++) begin
        if (valid[i] && m_rdy[i]) begin
          valid[i] = 1'b0;
        end else if (!valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            valid[i] = 1'b1;
            if (i == 0) d0 = 8'($urandom);
            else        d1 = 8'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          valid[i] = 1'b0;
        end
      end
    end
    drive_pt();
    valid = '0;
    repeat (FRAME + 2) samp_pt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
